cmp_pipe: RTL and testbench

//  Parametrised, pipelined compare unit; successor to the single-cycle ALU compare stage.

---
 rtl/cmp_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_cmp_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined compare unit with a valid/ready handshake on every stage.
// Stage 0 registers the operands and evaluates the compare result S combinationally
// from those registers; later stages only carry {S, tag} toward the output.
// Optional feature: define CMP_STICKY_EN to add the sticky_clr/sticky_s ports and the
// sticky result register.

module cmp_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [TAG_W-1:0] out_tag
`ifdef CMP_STICKY_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky_s
`endif
);

    // Number of {S, tag} stages behind stage 0 (kept at least 1 so arrays stay legal).
    localparam int unsigned NR = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic [2:0] OpNe  = 3'b000;
    localparam logic [2:0] OpEq  = 3'b001;
    localparam logic [2:0] OpLt  = 3'b010;
    localparam logic [2:0] OpGe  = 3'b011;
    localparam logic [2:0] OpLtz = 3'b100;
    localparam logic [2:0] OpGez = 3'b101;
    localparam logic [2:0] OpLez = 3'b110;
    localparam logic [2:0] OpGtz = 3'b111;

    // Stage 0 state: registered operands.
    logic             v0_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             sign_q;
    logic [TAG_W-1:0] tag0_q;

    // Later stage state: index j holds stage j+1.
    logic [NR-1:0]    vl_q;
    logic             s_q   [NR];
    logic [TAG_W-1:0] tag_q [NR];

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] leave;

    // Compare datapath.
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] diff;
    logic           lt;
    logic           eq;
    logic           ltz;
    logic           zero;
    logic           s0;

    // Evaluate S from the stage-0 registers with a WIDTH+1 bit subtract.
    always_comb begin
        // Sign- or zero-extend so the borrow bit is the exact A<B result.
        ext_a = {sign_q & a_q[WIDTH-1], a_q};
        ext_b = {sign_q & b_q[WIDTH-1], b_q};
        diff  = ext_a - ext_b;
        lt    = diff[WIDTH];
        eq    = ~|diff;
        ltz   = sign_q & a_q[WIDTH-1];
        zero  = ~|a_q;
        s0    = 1'b0;
        case (op_q)
            OpNe:    s0 = ~eq;
            OpEq:    s0 = eq;
            OpLt:    s0 = lt;
            OpGe:    s0 = ~lt;
            OpLtz:   s0 = ltz;
            OpGez:   s0 = ~ltz;
            OpLez:   s0 = ltz | zero;
            OpGtz:   s0 = ~(ltz | zero);
            default: s0 = 1'b0;
        endcase
    end

    // Ready chain from the output back to the input: a stage loads when empty or draining.
    always_comb begin
        logic chain;
        logic lv;
        logic ld;
        chain = out_ready;
        lv    = 1'b0;
        ld    = 1'b0;
        load  = '0;
        leave = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            lv       = v[k] & chain;
            ld       = ~v[k] | lv;
            leave[k] = lv;
            load[k]  = ld;
            chain    = ld;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v[STAGES-1];

    // Stage 0: capture a new transaction whenever the stage can load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v0_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
            tag0_q <= '0;
        end else begin
            if (load[0]) begin
                v0_q <= in_valid;
            end
            if (load[0] && in_valid) begin
                a_q    <= in_a;
                b_q    <= in_b;
                op_q   <= in_op;
                sign_q <= in_sign;
                tag0_q <= in_tag;
            end
        end
    end

    generate
        if (STAGES > 1) begin : g_later
            logic             s_in   [NR];
            logic [TAG_W-1:0] tag_in [NR];

            assign v = {vl_q, v0_q};

            // Feed of each later stage: stage 0 result for the first, predecessor otherwise.
            always_comb begin
                s_in[0]   = s0;
                tag_in[0] = tag0_q;
                for (int j = 1; j < NR; j++) begin
                    s_in[j]   = s_q[j-1];
                    tag_in[j] = tag_q[j-1];
                end
            end

            // Later stages: move {S, tag} forward when the stage loads.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vl_q <= '0;
                    for (int j = 0; j < NR; j++) begin
                        s_q[j]   <= 1'b0;
                        tag_q[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < NR; j++) begin
                        if (load[j+1]) begin
                            vl_q[j] <= v[j];
                        end
                        if (load[j+1] && v[j]) begin
                            s_q[j]   <= s_in[j];
                            tag_q[j] <= tag_in[j];
                        end
                    end
                end
            end

            assign out_s   = s_q[NR-1];
            assign out_tag = tag_q[NR-1];
        end else begin : g_single
            assign v       = v0_q;
            assign vl_q    = '0;
            assign out_s   = s0;
            assign out_tag = tag0_q;

            // Single-stage build keeps no later-stage state.
            always_comb begin
                for (int j = 0; j < NR; j++) begin
                    s_q[j]   = 1'b0;
                    tag_q[j] = '0;
                end
            end
        end
    endgenerate

`ifdef CMP_STICKY_EN
    logic sticky_q;

    // Sticky OR of transferred results; a same-cycle set wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr) | (out_valid & out_ready & out_s);
        end
    end

    assign sticky_s = sticky_q;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: directed and randomized checks of cmp_pipe (WIDTH=32/STAGES=2 and
// WIDTH=8/STAGES=3) against a value-level reference model and an in-order scoreboard.
// Sticky checks are compiled when CMP_STICKY_EN is defined.

module tb_cmp_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, out_valid, out_ready, out_s;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_op;
    logic [4:0]  in_tag, out_tag;

    logic        r8_in_valid, r8_in_ready, r8_in_sign, r8_out_valid, r8_out_ready, r8_out_s;
    logic [7:0]  r8_in_a, r8_in_b;
    logic [2:0]  r8_in_op;
    logic [4:0]  r8_in_tag, r8_out_tag;

`ifdef CMP_STICKY_EN
    logic sticky_clr, sticky_s, r8_sticky_clr, r8_sticky_s;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sign(in_sign), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_tag(out_tag)
`ifdef CMP_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky_s(sticky_s)
`endif
    );

    cmp_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(5)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(r8_in_valid), .in_ready(r8_in_ready),
        .in_a(r8_in_a), .in_b(r8_in_b), .in_op(r8_in_op), .in_sign(r8_in_sign),
        .in_tag(r8_in_tag), .out_valid(r8_out_valid), .out_ready(r8_out_ready),
        .out_s(r8_out_s), .out_tag(r8_out_tag)
`ifdef CMP_STICKY_EN
        , .sticky_clr(r8_sticky_clr), .sticky_s(r8_sticky_s)
`endif
    );

    // Reference: interpret the operands as integers and compare them arithmetically.
    function automatic bit ref_s(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input bit sgn, input int w);
        longint m, va, vb;
        m  = longint'(1) << w;
        va = longint'({32'd0, a});
        vb = longint'({32'd0, b});
        if (sgn && va >= m / 2) va = va - m;
        if (sgn && vb >= m / 2) vb = vb - m;
        case (op)
            3'd0: return va != vb;
            3'd1: return va == vb;
            3'd2: return va < vb;
            3'd3: return va >= vb;
            3'd4: return va < 0;
            3'd5: return va >= 0;
            3'd6: return va <= 0;
            default: return va > 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected {s, tag} pushed at each input transfer, popped at each output one.
    logic [5:0] q32[$];
    logic [5:0] q8[$];
    bit         held32;
    logic [5:0] hv32;

    always @(negedge clk) begin
        logic [5:0] e;
        if (!reset) begin
            q32.delete();
            held32 = 1'b0;
        end else begin
            if (held32) begin
                checks++;
                assert (out_valid === 1'b1 && {out_s, out_tag} === hv32) else begin
                    errors++;
                    $error("FAIL hold32 observed=%b/%h expected=1/%h", out_valid,
                           {out_s, out_tag}, hv32);
                end
            end
            held32 = out_valid && !out_ready;
            hv32   = {out_s, out_tag};
            if (out_valid && out_ready) begin
                checks++;
                assert (q32.size() != 0) else begin
                    errors++;
                    $error("FAIL pop32 observed=unexpected_result expected=none");
                end
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    checks++;
                    assert ({out_s, out_tag} === e) else begin
                        errors++;
                        $error("FAIL res32 observed=%h expected=%h", {out_s, out_tag}, e);
                    end
                end
            end
            if (in_valid && in_ready)
                q32.push_back({ref_s(in_a, in_b, in_op, in_sign, 32), in_tag});
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (!reset) begin
            q8.delete();
        end else begin
            if (r8_out_valid && r8_out_ready) begin
                checks++;
                assert (q8.size() != 0) else begin
                    errors++;
                    $error("FAIL pop8 observed=unexpected_result expected=none");
                end
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    checks++;
                    assert ({r8_out_s, r8_out_tag} === e) else begin
                        errors++;
                        $error("FAIL res8 observed=%h expected=%h", {r8_out_s, r8_out_tag}, e);
                    end
                end
            end
            if (r8_in_valid && r8_in_ready)
                q8.push_back({ref_s({24'd0, r8_in_a}, {24'd0, r8_in_b}, r8_in_op, r8_in_sign, 8),
                              r8_in_tag});
        end
    end

    // Present one transaction; returns at the negedge before the transfer edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic sg, input logic [4:0] tag);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sign = sg; in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] t2a [4] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t2b [4] = '{32'd5, 32'd5, 32'd0, 32'd0};
    logic [2:0]  t2op[4] = '{3'd1, 3'd0, 3'd2, 3'd2};
    logic        t2sg[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        t2s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] zva [3] = '{32'd0, 32'h8000_0000, 32'd1};

    initial begin
        int acc;
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_sign = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        r8_in_valid = 1'b0; r8_in_a = '0; r8_in_b = '0; r8_in_op = '0; r8_in_sign = 1'b0;
        r8_in_tag = '0; r8_out_ready = 1'b1;
`ifdef CMP_STICKY_EN
        sticky_clr = 1'b0; r8_sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_s", out_s, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Back-to-back stream, first result two cycles after acceptance.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
                in_valid = 1'b1; in_a = t2a[i]; in_b = t2b[i]; in_op = t2op[i];
                in_sign = t2sg[i]; in_tag = 5'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("b2b_in_ready", in_ready, 1);
            chk("b2b_out_valid", out_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) begin
                chk("b2b_out_s", out_s, t2s[i-2]);
                chk("b2b_out_tag", out_tag, i - 1);
            end
        end

        // Zero-compare and two-operand ops on boundary values, both signednesses.
        for (int ai = 0; ai < 3; ai++)
            for (int sg = 0; sg < 2; sg++)
                for (int op = 0; op < 8; op++)
                    send(zva[ai], $urandom, 3'(op), sg[0], 5'(ai * 16 + sg * 8 + op));
        idle();
        repeat (4) @(negedge clk);
        chk("zero_ops_drained", q32.size(), 0);

        // Fill with out_ready low; then release and expect simultaneous in/out transfer.
        @(posedge clk); #1; out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 32'(acc); in_b = 32'(acc & 1); in_op = 3'd1;
            in_sign = 1'b0; in_tag = 5'(16 + acc);
            @(negedge clk);
            if (in_ready) acc++;
        end
        chk("fill_accepts", acc, 2);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_out_valid", out_valid, 1);
        chk("fill_out_tag", out_tag, 16);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        send(32'd7, 32'd9, 3'd2, 1'b0, 5'd19);
        send(32'd9, 32'd7, 3'd3, 1'b1, 5'd20);
        idle();
        repeat (4) @(negedge clk);
        chk("fill_drained", q32.size(), 0);

`ifdef CMP_STICKY_EN
        send(32'd1, 32'd1, 3'd0, 1'b0, 5'd1);
        send(32'd1, 32'd1, 3'd1, 1'b0, 5'd2);
        send(32'd1, 32'd1, 3'd0, 1'b0, 5'd3);
        idle();
        repeat (4) @(negedge clk);
        chk("sticky_set", sticky_s, 1);
        @(posedge clk); #1; sticky_clr = 1'b1;
        @(posedge clk); #1; sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_alone", sticky_s, 0);
        @(posedge clk); #1; out_ready = 1'b0;
        send(32'd1, 32'd1, 3'd1, 1'b0, 5'd7);
        idle();
        repeat (3) @(negedge clk);
        chk("sticky_no_xfer", sticky_s, 0);
        @(posedge clk); #1; sticky_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_and_set", sticky_s, 1);
        repeat (3) @(negedge clk);
`endif

        // Mid-stream reset with transactions in flight and the output stalled.
        @(posedge clk); #1; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 3'(c);
            in_sign = 1'b1; in_tag = 5'(21 + c);
        end
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        @(posedge clk); #1; reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_s", out_s, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1; reset = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        // Random traffic on both widths with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            in_b      = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
            in_op     = 3'($urandom_range(0, 7));
            in_sign   = 1'($urandom_range(0, 1));
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            r8_in_valid  = ($urandom_range(0, 3) != 0);
            r8_in_a      = 8'($urandom);
            r8_in_b      = ($urandom_range(0, 3) == 0) ? r8_in_a : 8'($urandom);
            r8_in_op     = 3'($urandom_range(0, 7));
            r8_in_sign   = 1'($urandom_range(0, 1));
            r8_in_tag    = 5'($urandom);
            r8_out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; r8_in_valid = 1'b0; out_ready = 1'b1; r8_out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("rand32_drained", q32.size(), 0);
        chk("rand8_drained", q8.size(), 0);
        chk("rand32_idle", out_valid, 0);
        chk("rand8_idle", r8_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
